// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory port; data wins ties.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        IF_REQ,
   input  logic [31:0] IF_ADDR,
   output logic [31:0] IF_RDATA,
   output logic        IF_READY,
   input  logic        DM_REQ,
   input  logic [31:0] DM_ADDR,
   input  logic [31:0] DM_WDATA,
   input  logic [3:0]  DM_RW,
   output logic [31:0] DM_RDATA,
   output logic        DM_READY,
   output logic        MEM_REQ,
   output logic [31:0] MEM_ADDR,
   output logic [31:0] MEM_WDATA,
   output logic [3:0]  MEM_RW,
   input  logic [31:0] MEM_RDATA,
   input  logic        MEM_ACK,
   output logic        STALL,
   output logic        ERR
);

   typedef enum logic [1:0] {IDLE, DM_ACC, IF_ACC, RESP} state_t;

   if (MAX_WAIT < 2 || MAX_WAIT > 255) begin : g_max_wait_check
      $error("MAX_WAIT must be within 2..255");
   end

   state_t      state_q, state_d;
   logic        owner_dm_q, owner_dm_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_rw_q, mem_rw_d;
   logic [31:0] resp_q, resp_d;

`ifdef ARB_TIMEOUT_EN
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;
   logic [7:0] wait_q, wait_d;
   logic       err_q, err_d;
`endif

   always_comb begin
      state_d     = state_q;
      owner_dm_d  = owner_dm_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_rw_d    = mem_rw_q;
      resp_d      = resp_q;
`ifdef ARB_TIMEOUT_EN
      wait_d      = wait_q;
      err_d       = err_q;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef ARB_TIMEOUT_EN
            wait_d = '0;
            err_d  = 1'b0;
`endif
            if (DM_REQ) begin
               state_d     = DM_ACC;
               owner_dm_d  = 1'b1;
               mem_addr_d  = DM_ADDR;
               mem_wdata_d = DM_WDATA;
               mem_rw_d    = DM_RW;
            end else if (IF_REQ) begin
               state_d     = IF_ACC;
               owner_dm_d  = 1'b0;
               mem_addr_d  = IF_ADDR;
               mem_wdata_d = '0;
               mem_rw_d    = '0;
            end
         end
         DM_ACC, IF_ACC: begin
            if (MEM_ACK) begin
               state_d = RESP;
               // Stores complete with zero read data.
               resp_d  = (owner_dm_q && mem_rw_q[3]) ? '0 : MEM_RDATA;
            end
`ifdef ARB_TIMEOUT_EN
            else if (wait_q == 8'(MAX_WAIT - 1)) begin
               state_d = RESP;
               resp_d  = owner_dm_q ? '0 : NOP_INSN;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + 8'd1;
            end
`endif
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q     <= IDLE;
         owner_dm_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_rw_q    <= '0;
         resp_q      <= '0;
      end else begin
         state_q     <= state_d;
         owner_dm_q  <= owner_dm_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_rw_q    <= mem_rw_d;
         resp_q      <= resp_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         wait_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wait_q <= wait_d;
         err_q  <= err_d;
      end
   end

   assign ERR = (state_q == RESP) && err_q;
`else
   assign ERR = 1'b0;
`endif

   assign MEM_REQ   = (state_q == DM_ACC) || (state_q == IF_ACC);
   assign MEM_ADDR  = mem_addr_q;
   assign MEM_WDATA = mem_wdata_q;
   assign MEM_RW    = mem_rw_q;
   assign IF_READY  = (state_q == RESP) && !owner_dm_q;
   assign DM_READY  = (state_q == RESP) && owner_dm_q;
   assign IF_RDATA  = IF_READY ? resp_q : '0;
   assign DM_RDATA  = DM_READY ? resp_q : '0;
   assign STALL     = (IF_REQ && !IF_READY) || (DM_REQ && !DM_READY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model checked every cycle
// plus directed scenarios with hand-computed latencies and data.
module tb_mem_port_arbiter;

   localparam int unsigned MaxWait = 16;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        IF_REQ = 1'b0;
   logic [31:0] IF_ADDR = '0;
   logic [31:0] IF_RDATA;
   logic        IF_READY;
   logic        DM_REQ = 1'b0;
   logic [31:0] DM_ADDR = '0;
   logic [31:0] DM_WDATA = '0;
   logic [3:0]  DM_RW = '0;
   logic [31:0] DM_RDATA;
   logic        DM_READY;
   logic        MEM_REQ;
   logic [31:0] MEM_ADDR;
   logic [31:0] MEM_WDATA;
   logic [3:0]  MEM_RW;
   logic [31:0] MEM_RDATA = '0;
   logic        MEM_ACK = 1'b0;
   logic        STALL;
   logic        ERR;

   mem_port_arbiter #(.MAX_WAIT(MaxWait)) dut (
      .CLK(CLK), .RESET(RESET),
      .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_READY(IF_READY),
      .DM_REQ(DM_REQ), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA), .DM_RW(DM_RW),
      .DM_RDATA(DM_RDATA), .DM_READY(DM_READY),
      .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RW(MEM_RW),
      .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .STALL(STALL), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: ACKs ack_delay cycles after MEM_REQ rises, or on manual_ack.
   bit          auto_ack = 1'b1;
   int          ack_delay = 0;
   bit          manual_ack = 1'b0;
   logic [31:0] rdata_val = '0;
   int          req_age = 0;
   bit          prev_req = 1'b0;

   always @(posedge CLK) begin
      #2;
      req_age   = (MEM_REQ && prev_req) ? req_age + 1 : 0;
      prev_req  = MEM_REQ;
      MEM_ACK   = manual_ack || (auto_ack && MEM_REQ && req_age == ack_delay);
      MEM_RDATA = rdata_val;
   end

   // Transaction model: one access in flight, phase 0 free, 1 at memory, 2 answering.
   int          m_phase;
   bit          m_dm;
   bit          m_err;
   int          m_waited;
   logic [31:0] m_addr, m_wdata, m_resp;
   logic [3:0]  m_rw;

   always @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         m_phase = 0; m_dm = 0; m_err = 0; m_waited = 0;
         m_addr = '0; m_wdata = '0; m_resp = '0; m_rw = '0;
      end else if (m_phase == 0) begin
         m_err = 0;
         m_waited = 0;
         if (DM_REQ) begin
            m_phase = 1; m_dm = 1; m_addr = DM_ADDR; m_wdata = DM_WDATA; m_rw = DM_RW;
         end else if (IF_REQ) begin
            m_phase = 1; m_dm = 0; m_addr = IF_ADDR; m_wdata = '0; m_rw = '0;
         end
      end else if (m_phase == 1) begin
         if (MEM_ACK) begin
            m_phase = 2;
            m_resp = (m_dm && m_rw[3]) ? 32'h0 : MEM_RDATA;
         end
`ifdef ARB_TIMEOUT_EN
         else begin
            m_waited++;
            if (m_waited == MaxWait) begin
               m_phase = 2;
               m_err = 1;
               m_resp = m_dm ? 32'h0 : 32'h0000_0013;
            end
         end
`endif
      end else begin
         m_phase = 0;
      end
   end

   always @(negedge CLK) begin
      logic e_if, e_dm;
      e_if = (m_phase == 2) && !m_dm;
      e_dm = (m_phase == 2) && m_dm;
      check("mem_req", MEM_REQ, m_phase == 1);
      check("mem_addr", MEM_ADDR, m_addr);
      check("mem_wdata", MEM_WDATA, m_wdata);
      check("mem_rw", MEM_RW, m_rw);
      check("if_ready", IF_READY, e_if);
      check("dm_ready", DM_READY, e_dm);
      check("if_rdata", IF_RDATA, e_if ? m_resp : 32'h0);
      check("dm_rdata", DM_RDATA, e_dm ? m_resp : 32'h0);
      check("stall", STALL, (IF_REQ && !e_if) || (DM_REQ && !e_dm));
      check("err", ERR, (e_if || e_dm) && m_err);
   end

   // Runs a fixed number of cycles (cycle 1 = the cycle requests are first presented),
   // retiring requests after their READY and recording what was observed.
   task automatic serve(input int budget, input int drop_dm_at,
                        output int if_cyc, output int dm_cyc,
                        output logic [31:0] if_dat, output logic [31:0] dm_dat,
                        output logic [31:0] first_addr, output logic [3:0] first_rw,
                        output int req_cycles, output int err_cyc);
      bit got_addr = 0;
      bit drop_if, drop_dm;
      if_cyc = 0; dm_cyc = 0; if_dat = '0; dm_dat = '0;
      first_addr = 'x; first_rw = 'x; req_cycles = 0; err_cyc = 0;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(negedge CLK);
         drop_if = 0;
         drop_dm = (cyc == drop_dm_at);
         if (MEM_REQ) begin
            req_cycles++;
            if (!got_addr) begin
               first_addr = MEM_ADDR; first_rw = MEM_RW; got_addr = 1;
            end
         end
         if (IF_READY) begin if_cyc = cyc; if_dat = IF_RDATA; drop_if = 1; end
         if (DM_READY) begin dm_cyc = cyc; dm_dat = DM_RDATA; drop_dm = 1; end
         if (ERR) err_cyc = cyc;
         @(posedge CLK);
         #1;
         if (drop_if) IF_REQ = 0;
         if (drop_dm) DM_REQ = 0;
      end
      check("requests_retired", IF_REQ || DM_REQ, 0);
      IF_REQ = 0;
      DM_REQ = 0;
   endtask

   int          ifc, dmc, reqc, errc;
   logic [31:0] ifd, dmd, faddr;
   logic [3:0]  frw;

   initial begin
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_mem_req", MEM_REQ, 0);
      check("rst_mem_addr", MEM_ADDR, 0);
      check("rst_readies", {IF_READY, DM_READY, ERR}, 0);
      @(posedge CLK);
      #1 RESET = 1;

      // Single fetch, ACK in the first access cycle.
      rdata_val = 32'h0050_0093;
      IF_ADDR = 32'h100;
      IF_REQ = 1;
      serve(5, 0, ifc, dmc, ifd, dmd, faddr, frw, reqc, errc);
      check("fetch_latency", ifc, 3);
      check("fetch_rdata", ifd, 32'h0050_0093);
      check("fetch_addr", faddr, 32'h100);
      check("fetch_rw", frw, 4'b0000);
      check("fetch_req_cycles", reqc, 1);

      // Simultaneous requests: data store first, then the fetch.
      rdata_val = 32'h1111_1111;
      IF_ADDR = 32'h300;
      DM_ADDR = 32'h200;
      DM_WDATA = 32'hCAFE_F00D;
      DM_RW = 4'b1010;
      IF_REQ = 1;
      DM_REQ = 1;
      serve(8, 0, ifc, dmc, ifd, dmd, faddr, frw, reqc, errc);
      check("tie_dm_latency", dmc, 3);
      check("tie_if_latency", ifc, 6);
      check("tie_store_rdata", dmd, 32'h0);
      check("tie_if_rdata", ifd, 32'h1111_1111);
      check("tie_first_addr", faddr, 32'h200);
      check("tie_first_rw", frw, 4'b1010);

      // Load with ACK delayed five cycles.
      ack_delay = 5;
      rdata_val = 32'hDEAD_BEEF;
      DM_ADDR = 32'h400;
      DM_RW = 4'b0010;
      DM_REQ = 1;
      serve(10, 0, ifc, dmc, ifd, dmd, faddr, frw, reqc, errc);
      check("slow_load_latency", dmc, 8);
      check("slow_load_rdata", dmd, 32'hDEAD_BEEF);
      check("slow_load_req_cycles", reqc, 6);

      // Requester drops DM_REQ mid-access; the access still completes.
      ack_delay = 3;
      rdata_val = 32'h0BAD_CAFE;
      DM_ADDR = 32'h700;
      DM_RW = 4'b0100;
      DM_REQ = 1;
      serve(8, 2, ifc, dmc, ifd, dmd, faddr, frw, reqc, errc);
      check("drop_latency", dmc, 6);
      check("drop_rdata", dmd, 32'h0BAD_CAFE);
      check("drop_req_cycles", reqc, 4);

      // Reset while a load is waiting; a late ACK after release must be ignored.
      auto_ack = 0;
      ack_delay = 0;
      DM_ADDR = 32'h500;
      DM_RW = 4'b0000;
      DM_REQ = 1;
      repeat (2) begin @(posedge CLK); #1; end
      #2;
      RESET = 0;
      DM_REQ = 0;
      #1;
      check("rst_mid_mem_req", MEM_REQ, 0);
      check("rst_mid_mem_addr", MEM_ADDR, 0);
      check("rst_mid_outputs", {DM_READY, IF_READY, ERR, STALL, MEM_RW}, 0);
      @(posedge CLK);
      #1 RESET = 1;
      manual_ack = 1;
      rdata_val = 32'h1234_5678;
      @(posedge CLK);
      #1 manual_ack = 0;
      serve(4, 0, ifc, dmc, ifd, dmd, faddr, frw, reqc, errc);
      check("late_ack_no_ready", ifc + dmc, 0);
      check("late_ack_no_req", reqc, 0);
      auto_ack = 1;
      rdata_val = 32'h0000_0033;
      IF_ADDR = 32'h140;
      IF_REQ = 1;
      serve(5, 0, ifc, dmc, ifd, dmd, faddr, frw, reqc, errc);
      check("post_rst_latency", ifc, 3);
      check("post_rst_addr", faddr, 32'h140);

`ifdef ARB_TIMEOUT_EN
      // Fetch never acknowledged: watchdog answers with a NOP and ERR.
      auto_ack = 0;
      IF_ADDR = 32'h600;
      IF_REQ = 1;
      serve(21, 0, ifc, dmc, ifd, dmd, faddr, frw, reqc, errc);
      check("timeout_latency", ifc, 18);
      check("timeout_rdata", ifd, 32'h0000_0013);
      check("timeout_req_cycles", reqc, MaxWait);
      check("timeout_err_cycle", errc, 18);
      auto_ack = 1;
`endif

      repeat (2) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, tests %0d failed %0d",
               tests, fails);
      $fatal(1, "bench time limit expired");
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 16, watchdog limit in cycles (legal 2..255); used only when ARB_TIMEOUT_EN is defined.
REQ-002 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port: RESET  input  1  asynchronous, active-low reset.
REQ-004 Port: IF_REQ  input  1  instruction-fetch request; held by requester until IF_READY.
REQ-005 Port: IF_ADDR  input  32  fetch address.
REQ-006 Port: IF_RDATA  output  32  fetched instruction, valid while IF_READY=1.
REQ-007 Port: IF_READY  output  1  one-cycle completion pulse for fetch.
REQ-008 Port: DM_REQ  input  1  data-access request; held until DM_READY.
REQ-009 Port: DM_ADDR  input  32  data address.
REQ-010 Port: DM_WDATA  input  32  store data.
REQ-011 Port: DM_RW  input  4  access code; bit3=1 store, bit3=0 load, bits[2:0] size/sign, passed through unchanged.
REQ-012 Port: DM_RDATA  output  32  load data, valid while DM_READY=1.
REQ-013 Port: DM_READY  output  1  one-cycle completion pulse for data access.
REQ-014 Port: MEM_REQ  output  1  shared-memory request, held until MEM_ACK.
REQ-015 Port: MEM_ADDR, MEM_WDATA  output  32 each  latched address/store data of the granted requester.
REQ-016 Port: MEM_RW  output  4  latched access code; 4'b0000 for fetches.
REQ-017 Port: MEM_RDATA  input  32  memory read data, sampled in the MEM_ACK cycle.
REQ-018 Port: MEM_ACK  input  1  memory completion, any latency >=0 cycles after MEM_REQ rises.
REQ-019 Port: STALL  output  1  pipeline freeze = (IF_REQ & ~IF_READY) | (DM_REQ & ~DM_READY), combinational.
REQ-020 Port: ERR  output  1  one-cycle timeout pulse.

Function
REQ-021 FSM states SHALL be IDLE, DM_ACC, IF_ACC, RESP.
REQ-022 IDLE: DM_REQ=1 -> DM_ACC; else IF_REQ=1 -> IF_ACC; else stay; address/data/code latched on the transition edge.
REQ-023 Simultaneous IF_REQ and DM_REQ in IDLE SHALL grant data first; fetch granted at the next IDLE.
REQ-024 DM_ACC/IF_ACC: MEM_REQ=1 with latched outputs stable; MEM_ACK=1 captures MEM_RDATA into a 32-bit response register and moves to RESP.
REQ-025 RESP: exactly one of IF_READY/DM_READY=1 for one cycle with the response register on the matching RDATA; next state IDLE.
REQ-026 Minimum latency request-to-READY SHALL be 3 cycles (IDLE sample, ACC with same-cycle ACK, RESP); each extra ACK-wait cycle adds one.
REQ-027 MEM_ACK outside DM_ACC/IF_ACC SHALL be ignored.
REQ-028 Requester dropping REQ mid-access: access still completes, READY still pulses, no new grant until IDLE.
REQ-029 Stores SHALL pulse DM_READY with DM_RDATA=0.
REQ-030 IF_RDATA/DM_RDATA SHALL be 0 whenever their READY is 0.

Reset
REQ-031 RESET=0 SHALL asynchronously force IDLE and all outputs to 0 (MEM_REQ, MEM_ADDR, MEM_WDATA, MEM_RW, both READY, both RDATA, ERR, response register, watchdog counter); STALL follows its equation.
REQ-032 Reset during DM_ACC/IF_ACC SHALL abandon the access; a late MEM_ACK after release is ignored.

Configuration
REQ-033 Macro ARB_TIMEOUT_EN defined: an 8-bit counter clears on ACC entry, increments each ACC cycle without MEM_ACK; reaching MAX_WAIT drops MEM_REQ, enters RESP, pulses ERR with READY, response = 32'h00000013 (NOP) for fetch, 32'h0 for data.
REQ-034 ARB_TIMEOUT_EN undefined: no counter, ACC waits indefinitely, ERR tied 0.

Verification
REQ-035 Single fetch, IF_ADDR=0x100, ACK in first ACC cycle with 0x00500093 -> IF_READY at cycle 3, IF_RDATA=0x00500093, MEM_RW=0.
REQ-036 IF_REQ and DM_REQ rise together, DM_RW=4'b1010, DM_ADDR=0x200 -> MEM_ADDR=0x200 first, DM_READY, then MEM_ADDR=IF_ADDR, IF_READY; STALL high until both done.
REQ-037 Load with ACK delayed 5 cycles, MEM_RDATA=0xDEADBEEF -> DM_READY at cycle 8, DM_RDATA=0xDEADBEEF, MEM_REQ steady 6 cycles.
REQ-038 RESET low in DM_ACC, ACK 1 cycle after release -> all outputs 0, no READY, FSM IDLE.
REQ-039 ARB_TIMEOUT_EN, MAX_WAIT=16, no ACK on fetch -> MEM_REQ drops after 16 ACC cycles, IF_READY+ERR together, IF_RDATA=0x00000013.
